// File: rtl/alu_logic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_logic_pkg
// Brief    : Shared opcode/state types for the sequenced bitwise logic unit.
// Revision : 1.0
// ============================================================================
package alu_logic_pkg;

    typedef enum logic [1:0] {
        LOP_AND = 2'b00,
        LOP_OR  = 2'b01,
        LOP_XOR = 2'b10,
        LOP_NOR = 2'b11
    } logic_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice counter width, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/logic_seq_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_seq_unit_if
// Brief    : Request/result handshake bundle of the sequenced logic unit.
//            o_zero exists only when LOGIC_SEQ_ZERO_FLAG_EN is defined.
// Revision : 1.0
// ============================================================================
interface logic_seq_unit_if
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic_op_e        i_op;
    logic [WIDTH-1:0] i_1;
    logic [WIDTH-1:0] i_2;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic             o_zero;
`endif

    modport master (
        output i_valid, i_op, i_1, i_2, i_ready,
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        input  o_zero,
`endif
        input  o_ready, o_valid, o
    );

    modport slave (
        input  i_valid, i_op, i_1, i_2, i_ready,
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        output o_zero,
`endif
        output o_ready, o_valid, o
    );
endinterface
`default_nettype wire

// File: rtl/logic_seq_unit_slice.sv
`default_nettype none
// ============================================================================
// Module   : logic_slice
// Brief    : Combinational CHUNK-bit AND/OR/XOR/NOR evaluator.
// Revision : 1.0
// ============================================================================
module logic_slice
    import alu_logic_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic_op_e        i_op,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    output logic [CHUNK-1:0] o_y
);
    always_comb begin
        o_y = '0;
        case (i_op)
            LOP_AND: o_y = i_a & i_b;
            LOP_OR:  o_y = i_a | i_b;
            LOP_XOR: o_y = i_a ^ i_b;
            LOP_NOR: o_y = ~(i_a | i_b);
            default: o_y = '0;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/logic_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : logic_seq_unit
// Brief    : Handshaked bitwise logic unit evaluating one CHUNK slice per
//            cycle. Define LOGIC_SEQ_ZERO_FLAG_EN to add the o_zero flag.
// Revision : 1.0
// ============================================================================
module logic_seq_unit
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  wire              clk,
    input  wire              rst_n,
    logic_seq_unit_if.slave  bus
);
    localparam int NSLICE = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int CNT_W  = cnt_width(NSLICE);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NSLICE - 1);

    if ((CHUNK < 1) || ((WIDTH % ((CHUNK >= 1) ? CHUNK : 1)) != 0)) begin : g_bad_chunk
        $error("logic_seq_unit: WIDTH must be a multiple of CHUNK and CHUNK >= 1");
    end
    if ($bits(bus.o) != WIDTH) begin : g_bad_if_width
        $error("logic_seq_unit: interface WIDTH differs from unit WIDTH");
    end

    state_e           r_state;
    logic_op_e        r_op;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_y;
    logic [WIDTH-1:0] w_next_result;

    assign w_a = r_op1[int'(r_cnt)*CHUNK +: CHUNK];
    assign w_b = r_op2[int'(r_cnt)*CHUNK +: CHUNK];

    logic_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .i_op (r_op),
        .i_a  (w_a),
        .i_b  (w_b),
        .o_y  (w_y)
    );

    // Result with the current slice merged in; on the last slice this is the full result.
    always_comb begin
        w_next_result = r_result;
        w_next_result[int'(r_cnt)*CHUNK +: CHUNK] = w_y;
    end

`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic r_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_op     <= LOP_AND;
            r_op1    <= '0;
            r_op2    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            r_zero   <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_valid) begin
                        r_op    <= bus.i_op;
                        r_op1   <= bus.i_1;
                        r_op2   <= bus.i_2;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_result <= w_next_result;
                    if (r_cnt == C_LAST) begin
                        r_state <= DONE;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                        r_zero  <= (w_next_result == '0);
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_ready = (r_state == IDLE);
    assign bus.o_valid = (r_state == DONE);
    assign bus.o       = r_result;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    assign bus.o_zero  = r_zero;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_seq_unit
// Brief    : Directed plus randomized checks of logic_seq_unit against a
//            word-level reference model.
// Revision : 1.0
// ============================================================================
module tb_logic_seq_unit
    import alu_logic_pkg::*;
#(
    parameter int CHUNK = 8
);
    localparam int WIDTH  = 32;
    localparam int NSLICE = WIDTH / CHUNK;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    logic_seq_unit_if #(.WIDTH(WIDTH)) bus ();

    logic_seq_unit #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input int op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic check_zero(input string tag, input logic [WIDTH-1:0] exp);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        check(tag, 64'(bus.o_zero), 64'(exp == '0));
`endif
    endtask

    task automatic garble();
        bus.i_valid = 1'($urandom_range(0, 1));
        bus.i_op    = logic_op_e'($urandom_range(0, 3));
        bus.i_1     = $urandom;
        bus.i_2     = $urandom;
    endtask

    // One full transaction: accept, busy with garbage inputs, stall in DONE, drain.
    task automatic do_op(input int op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int stall);
        logic [WIDTH-1:0] exp;
        int lat;
        exp = ref_op(op, a, b);
        @(negedge clk);
        check("ready_idle", 64'(bus.o_ready), 64'd1);
        bus.i_valid = 1'b1;
        bus.i_op    = logic_op_e'(op);
        bus.i_1     = a;
        bus.i_2     = b;
        @(negedge clk);
        lat = 0;
        while (!bus.o_valid && lat <= NSLICE + 4) begin
            check("ready_busy", 64'(bus.o_ready), 64'd0);
            garble();
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(NSLICE));
        check("result", 64'(bus.o), 64'(exp));
        check_zero("zero", exp);
        for (int s = 0; s < stall; s++) begin
            garble();
            @(negedge clk);
            check("hold_valid", 64'(bus.o_valid), 64'd1);
            check("hold_ready", 64'(bus.o_ready), 64'd0);
            check("hold_result", 64'(bus.o), 64'(exp));
            check_zero("hold_zero", exp);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check("drain_valid", 64'(bus.o_valid), 64'd0);
        check("drain_ready", 64'(bus.o_ready), 64'd1);
        check("idle_result", 64'(bus.o), 64'(exp));
    endtask

    initial begin
        int op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.i_valid = 1'b0;
        bus.i_op    = LOP_AND;
        bus.i_1     = '0;
        bus.i_2     = '0;
        bus.i_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(bus.o_valid), 64'd0);
        check("rst_ready", 64'(bus.o_ready), 64'd1);
        check("rst_result", 64'(bus.o), 64'd0);
        check_zero("rst_zero", '0);
        rst_n = 1'b1;

        do_op(1, 32'hF0F0_0000, 32'h0F0F_00FF, 0);
        check("or_known", 64'(bus.o), 64'hFFFF_00FF);
        do_op(3, 32'h0000_0000, 32'h0000_0000, 1);
        do_op(2, 32'hAAAA_5555, 32'hFFFF_0000, 0);
        do_op(0, 32'h1234_5678, 32'h0F0F_0F0F, 5);
        check("and_known", 64'(bus.o), 64'h0204_0608);
        do_op(0, 32'hFF00_FF00, 32'h00FF_00FF, 2);
        do_op(1, 32'hFF00_FF00, 32'h00FF_00FF, 2);

        // Asynchronous reset during the second BUSY cycle discards the op.
        @(negedge clk);
        bus.i_valid = 1'b1;
        bus.i_op    = LOP_OR;
        bus.i_1     = 32'hDEAD_BEEF;
        bus.i_2     = 32'h1234_5678;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(bus.o_valid), 64'd0);
        check("midrst_ready", 64'(bus.o_ready), 64'd1);
        check("midrst_result", 64'(bus.o), 64'd0);
        check_zero("midrst_zero", '0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(2, 32'h0F0F_F0F0, 32'h3C3C_3C3C, 1);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                op = 0;
                b  = ~a;
            end
            do_op(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
